// File: rtl/ebike_led_pkg.sv
// Shared types and helpers for the assist-level LED driver.
// Holds the blink FSM state type and the thermometer encoder for the level bar.
package ebike_led_pkg;

   // Blink pattern sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } blink_state_t;

   // Map a 2-bit assist setting onto a 3-LED thermometer bar
   function automatic logic [2:0] therm3(input logic [1:0] level);
      logic [2:0] code;
      case (level)
         2'b00:   code = 3'b000;
         2'b01:   code = 3'b001;
         2'b10:   code = 3'b011;
         default: code = 3'b111;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/assist_led_drv_phase_timer.sv
// phase_timer: counts the cycles of one blink ON or OFF phase.
// Counts 0..BLINK_TICKS-1 while enabled and wraps to 0 by itself, so the
// sequencer only has to clear it when a pattern (re)starts or aborts.
module phase_timer #(
   parameter int BLINK_TICKS = 25_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam int CW = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BLINK_TICKS - 1);

   logic [CW-1:0] cnt_reg;
   logic          at_last;

   assign at_last = (cnt_reg == LAST);
   // A clear in the same cycle wins, so a restart never sees a stale expiry
   assign done    = en && at_last && !clr;

   // Phase tick counter: clear on request, wrap at the end of each phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (en) begin
         if (at_last) begin
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/assist_led_drv.sv
// assist_led_drv: thermometer level bar plus a change indicator that blinks
// N times (N = new setting) whenever the assist setting changes.
// Optional bar dimming is enabled by defining LED_PWM_EN.
module assist_led_drv
   import ebike_led_pkg::*;
#(
   parameter int BLINK_TICKS = 25_000_000,
   parameter int PWM_DUTY    = 128
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] setting,
   output logic [2:0] led_lvl,
   output logic       led_blink,
   output logic       busy
);

   // Elaboration-time parameter sanity
   if (BLINK_TICKS < 2) begin : g_bad_ticks
      $error("BLINK_TICKS must be at least 2");
   end
   if ((PWM_DUTY < 0) || (PWM_DUTY > 255)) begin : g_bad_duty
      $error("PWM_DUTY must be in 0..255");
   end

   logic [1:0]   setting_q_reg;
   logic         chg;
   blink_state_t state_reg, state_next;
   logic [1:0]   blinks_reg, blinks_next;
   logic [1:0]   blinks_dec;
   logic         led_blink_reg, busy_reg;
   logic         timer_clr, timer_en, timer_done;
   logic [2:0]   therm;
   logic         pwm_on;

   assign chg        = (setting != setting_q_reg);
   assign blinks_dec = blinks_reg - 2'd1;
   assign timer_en   = (state_reg != IDLE);

   phase_timer #(
      .BLINK_TICKS(BLINK_TICKS)
   ) u_phase_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (timer_clr),
      .en   (timer_en),
      .done (timer_done)
   );

   // Accept the setting every cycle; chg is the difference against last cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         setting_q_reg <= 2'b00;
      end else begin
         setting_q_reg <= setting;
      end
   end

   // Next-state logic: a change overrides everything, including a final OFF expiry
   always_comb begin
      state_next  = state_reg;
      blinks_next = blinks_reg;
      timer_clr   = 1'b0;
      if (chg) begin
         timer_clr = 1'b1;
         if (setting != 2'b00) begin
            state_next  = ON;
            blinks_next = setting;
         end else begin
            state_next  = IDLE;
            blinks_next = 2'd0;
         end
      end else begin
         case (state_reg)
            ON: begin
               if (timer_done) begin
                  state_next = OFF;
               end
            end
            OFF: begin
               if (timer_done) begin
                  blinks_next = blinks_dec;
                  state_next  = (blinks_dec == 2'd0) ? IDLE : ON;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // State register; outputs are registered from the next state so they
   // track the state they describe without a combinational path to the pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         blinks_reg    <= 2'd0;
         led_blink_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         blinks_reg    <= blinks_next;
         led_blink_reg <= (state_next == ON);
         busy_reg      <= (state_next != IDLE);
      end
   end

   assign led_blink = led_blink_reg;
   assign busy      = busy_reg;
   assign therm     = therm3(setting_q_reg);

`ifdef LED_PWM_EN
   logic [7:0] pwm_cnt_reg;

   // Free-running PWM counter that sets the bar brightness period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_reg <= 8'd0;
      end else begin
         pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
      end
   end

   assign pwm_on = (pwm_cnt_reg < 8'(PWM_DUTY));
`else
   assign pwm_on = 1'b1;
`endif

   // Gate each bar LED with the brightness enable
   for (genvar gi = 0; gi < 3; gi++) begin : g_bar
      assign led_lvl[gi] = therm[gi] & pwm_on;
   end

endmodule

// File: doc/assist_led_drv.md
# assist_led_drv

Rider-feedback LED driver for the assist-level setting. It consumes the 2-bit assist setting from the push-button interface and drives a 3-LED thermometer bar showing the current level. It also drives a single indicator LED that blinks N times whenever the setting changes, where N is the new setting value. It sits between the push-button interface and the handlebar LED pins.

## Interface
- `BLINK_TICKS`, default 25_000_000: clocks per blink ON phase and per OFF phase; minimum 2.
- `PWM_DUTY`, default 128: bar brightness as on-count out of 256; used only with `LED_PWM_EN`.
- `clk` input, 1: system clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `setting` input, 2: assist setting (00 off, 01 low, 10 medium, 11 max); synchronous to `clk`.
- `led_lvl` output, 3: thermometer bar.
- `led_blink` output, 1: change-indicator LED.
- `busy` output, 1: high while a blink pattern is in progress.

## Operation
- `setting_q` register holds the last accepted setting; it resets to 2'b00.
- `chg` = (`setting` != `setting_q`), combinational. `setting_q` loads `setting` every cycle.
- Thermometer mapping from `setting_q`: 00→000, 01→001, 10→011, 11→111.
- FSM states: IDLE, ON, OFF.
  - `chg` with `setting`≠0, in any state: go to ON, load `blinks_left` = `setting`, clear the tick counter. A change mid-pattern restarts the pattern with the new count.
  - `chg` with `setting`==0, in any state: go to IDLE. Any pattern in progress is aborted.
  - ON: after BLINK_TICKS cycles, go to OFF and clear the tick counter.
  - OFF: after BLINK_TICKS cycles, decrement `blinks_left`. If the result is 0, go to IDLE; otherwise go to ON.
- The tick counter is $clog2(BLINK_TICKS) bits wide. It counts 0..BLINK_TICKS-1, then wraps to 0 on each phase transition.
- `led_blink` = registered (state==ON). `busy` = registered (state!=IDLE).
- Reset mid-pattern: everything returns to reset values immediately (asynchronous). After release, the FSM re-detects against `setting_q`=00.

## Timing
- Reset values: `led_lvl`=000, `led_blink`=0, `busy`=0, state IDLE, `setting_q`=00, `blinks_left`=0, counters 0.
- `setting` changes during cycle k:
  - the FSM enters ON at the end of cycle k;
  - `led_blink` and `busy` go high in cycle k+1;
  - `led_lvl` shows the new level in cycle k+1.
- Each ON phase and each OFF phase lasts exactly BLINK_TICKS cycles on `led_blink`.
- A pattern of N blinks occupies 2·N·BLINK_TICKS cycles of `busy`. `busy` falls in the cycle after the last OFF phase ends.
- A new change arriving in the same cycle as a final OFF expiry takes priority: the FSM enters ON, not IDLE.
- `setting` held constant produces no further `chg`; the pattern plays once.

## Configuration
- `LED_PWM_EN` defined:
  - an 8-bit free-running counter (reset 0) dims the bar;
  - `led_lvl` = thermometer AND (`pwm_cnt` < `PWM_DUTY`);
  - `PWM_DUTY`=0 gives a dark bar; 256 is not allowed.
- `LED_PWM_EN` undefined: `led_lvl` = thermometer, steady. No PWM counter is instantiated and `PWM_DUTY` is ignored.
- `led_blink` is never PWM-dimmed.

## Structure
- Package `ebike_led_pkg` holds:
  - the state typedef `blink_state_t` {IDLE, ON, OFF};
  - the function `therm3(logic [1:0])` returning the 3-bit thermometer code.
- One sub-module, `phase_timer`:
  - parameter BLINK_TICKS;
  - inputs `clr` and `en`;
  - output `done`, a single-cycle pulse when the count reaches BLINK_TICKS-1.
- The FSM, `setting_q` and the optional PWM live in the top module.

## Test plan
(BLINK_TICKS=4, `LED_PWM_EN` undefined unless stated.)
- Reset release with `setting`=10 → `led_lvl`=011 from cycle 1. `led_blink` is high cycles 1–4 and 9–12, low otherwise. `busy` is high cycles 1–16 and low from 17.
- Setting 10→11 while idle → three blinks, `busy` high for 24 cycles, `led_lvl`=111.
- Setting 11→01 during the second ON phase → pattern restarts the next cycle. Exactly one 4-cycle blink follows, and `led_lvl`=001.
- Setting →00 mid-pattern → `led_blink`=0 and `busy`=0 the next cycle, `led_lvl`=000.
- Assert `rst_n` low mid-OFF phase → all outputs are 0 in the same cycle. After release with `setting`=01, one blink.
- With `LED_PWM_EN` defined, PWM_DUTY=64 and `setting`=11 → each `led_lvl` bit is high 64 of every 256 cycles, in phase with the PWM counter.
